// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, WIDTH-bit operands, with signed mode and optional early exit.
// Takes 1..WIDTH CALC cycles, then FIXUP, then a one-cycle DONE pulse.
module seq_mult_param #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int CW        = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [CW-1:0]        iterations,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t cur, nxt;

  logic [2*WIDTH-1:0] md, acc, acc_fix;
  logic [WIDTH-1:0]   mr, mr_next, a_mag, b_mag;
  logic [CW-1:0]      count, count_inc;
  logic               neg, last_iter;

  // Magnitudes: -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
  assign a_mag     = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_mode && b[WIDTH-1]) ? -b : b;
  assign mr_next   = mr >> 1;
  assign count_inc = count + CW'(1);
  assign last_iter = (count_inc == CW'(WIDTH)) || (EARLY_EXIT && (mr_next == '0));
  assign acc_fix   = neg ? -acc : acc;
  assign state     = cur;

  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (start) nxt = CALC;
      CALC:    if (last_iter) nxt = FIXUP;
      FIXUP:   nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (cur != IDLE);
    done = (cur == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md         <= '0;
      mr         <= '0;
      acc        <= '0;
      count      <= '0;
      neg        <= 1'b0;
      product    <= '0;
      iterations <= '0;
    end else begin
      case (cur)
        IDLE: begin
          if (start) begin
            md    <= {{WIDTH{1'b0}}, a_mag};
            mr    <= b_mag;
            acc   <= '0;
            count <= '0;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        CALC: begin
          if (mr[0]) acc <= acc + md;
          md    <= md << 1;
          mr    <= mr_next;
          count <= count_inc;
        end
        // Result registers load on the FIXUP edge so they are already visible during DONE.
        FIXUP: begin
          acc        <= acc_fix;
          product    <= acc_fix;
          iterations <= count;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: one early-exit instance and one full-length instance.
module tb_seq_mult_param;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          start1 = 0, sm1 = 0, start0 = 0, sm0 = 0;
  logic [W-1:0]  a1 = 0, b1 = 0, a0 = 0, b0 = 0;
  logic          busy1, done1, busy0, done0;
  logic [2*W-1:0] prod1, prod0;
  logic [CW-1:0] it1, it0;
  logic [1:0]    st1, st0;

  seq_mult_param #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .product(prod1), .iterations(it1), .state(st1));

  seq_mult_param #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .product(prod0), .iterations(it0), .state(st0));

  typedef struct {
    logic [2*W-1:0] p;
    int             it;
    int             cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer multiply; iteration count from the magnitude's bit length.
  function automatic exp_t model(bit sm, logic [W-1:0] a, logic [W-1:0] b, bit ee, int c);
    exp_t   e;
    longint sa, sb, p, m;
    int     k;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    e.p = p[2*W-1:0];
    if (ee) begin
      m = (sb < 0) ? -sb : sb;
      k = 0;
      while (m > 0) begin
        m = m >> 1;
        k++;
      end
      if (k == 0) k = 1;
    end else begin
      k = W;
    end
    e.it  = k;
    e.cyc = c + k + 2;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) chk("spurious_done1", done1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("product1", prod1, e.p);
        chk("iterations1", it1, e.it);
        chk("done_cycle1", cyc, e.cyc);
        chk("busy_at_done1", busy1, 1);
      end
    end
    if (done0) begin
      if (q0.size() == 0) chk("spurious_done0", done0, 0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("product0", prod0, e.p);
        chk("iterations0", it0, e.it);
        chk("done_cycle0", cyc, e.cyc);
        chk("busy_at_done0", busy0, 1);
      end
    end
  end

  task automatic wait_idle(bit which);
    int n;
    n = 0;
    @(negedge clk);
    while (((which ? st1 : st0) != 2'd0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", n, 0);
  endtask

  task automatic issue(bit which, bit sm, logic [W-1:0] a, logic [W-1:0] b);
    wait_idle(which);
    if (which) begin
      start1 = 1; sm1 = sm; a1 = a; b1 = b;
      q1.push_back(model(sm, a, b, 1'b1, cyc));
    end else begin
      start0 = 1; sm0 = sm; a0 = a; b0 = b;
      q0.push_back(model(sm, a, b, 1'b0, cyc));
    end
    @(negedge clk);
    if (which) begin
      chk("calc_entry1", st1, 1);
      chk("busy_after_start1", busy1, 1);
      start1 = 0; sm1 = 1'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    end else begin
      chk("calc_entry0", st0, 1);
      start0 = 0; sm0 = 1'($urandom); a0 = W'($urandom); b0 = W'($urandom);
    end
  endtask

  initial begin
    int c;
    int n;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_state1", st1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_product1", prod1, 0);
    chk("rst_iter1", it1, 0);
    chk("rst_state0", st0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_product0", prod0, 0);

    issue(1, 0, 8'd13, 8'd11);
    issue(1, 1, 8'hFD, 8'h05);
    issue(1, 1, 8'h80, 8'h80);
    issue(1, 0, 8'h37, 8'h00);
    issue(1, 1, 8'hFF, 8'h00);
    issue(1, 1, 8'h80, 8'h7F);

    // Reset in the middle of CALC: no done, everything cleared the next cycle.
    wait_idle(1);
    c = cyc;
    start1 = 1; sm1 = 0; a1 = 8'hAA; b1 = 8'hFF;
    @(negedge clk);
    start1 = 0;
    while (cyc < c + 3) @(negedge clk);
    chk("pre_rst_calc", st1, 1);
    rst = 1;
    @(negedge clk);
    chk("midrst_state", st1, 0);
    chk("midrst_busy", busy1, 0);
    chk("midrst_product", prod1, 0);
    chk("midrst_done", done1, 0);
    rst = 0;
    repeat (12) @(negedge clk);
    issue(1, 0, 8'd7, 8'd6);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom) >> $urandom_range(0, 8);
      issue(1, 1'($urandom), ra, rb);
    end

    // Start held high across a whole op: the next acceptance is the IDLE cycle after DONE.
    wait_idle(0);
    c = cyc;
    start0 = 1; sm0 = 0; a0 = 8'hFF; b0 = 8'hFF;
    q0.push_back(model(0, 8'hFF, 8'hFF, 1'b0, c));
    q0.push_back(model(0, 8'hFF, 8'hFF, 1'b0, c + W + 3));
    while (cyc < c + W + 4) @(negedge clk);
    start0 = 0;

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom) >> $urandom_range(0, 8);
      issue(0, 1'($urandom), ra, rb);
    end

    n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain1", q1.size(), 0);
    chk("drain0", q0.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
